// File: rtl/tilelink_pkg.sv
// TileLink-UL shared widths, A/D opcodes and the packed D-channel response
// descriptor used by the SRAM bridge and its response FIFO.
package tilelink_pkg;

    localparam int TL_AW   = 32;
    localparam int TL_DW   = 32;
    localparam int TL_DBW  = TL_DW / 8;
    localparam int TL_SZW  = 3;
    localparam int TL_SRCW = 8;
    localparam int TL_OFF  = $clog2(TL_DBW);

    typedef enum logic [2:0] {
        PutFullData    = 3'd0,
        PutPartialData = 3'd1,
        Get            = 3'd4
    } tl_a_opcode_e;

    typedef enum logic [2:0] {
        AccessAck     = 3'd0,
        AccessAckData = 3'd1
    } tl_d_opcode_e;

    typedef struct packed {
        tl_d_opcode_e        opcode;
        logic [TL_SZW-1:0]   size;
        logic [TL_SRCW-1:0]  source;
        logic [TL_DW-1:0]    data;
        logic                error;
    } tl_d_rsp_t;

    // Contiguous byte-lane mask covering 2**size bytes starting at lane lo.
    function automatic logic [TL_DBW-1:0] tl_full_mask(input logic [TL_SZW-1:0] size,
                                                       input logic [TL_OFF-1:0] lo);
        logic [TL_DBW-1:0] m;
        m = '0;
        for (int unsigned i = 0; i < TL_DBW; i++) begin
            if (i < (32'd1 << size)) m = {m[TL_DBW-2:0], 1'b1};
        end
        return m << lo;
    endfunction

endpackage

// File: rtl/tl_a_intf.sv
// TileLink-UL A channel bundle; the slave side returns only ready.
interface tl_a_intf;
    import tilelink_pkg::*;

    logic                valid;
    logic                ready;
    logic [2:0]          opcode;
    logic [TL_SZW-1:0]   size;
    logic [TL_SRCW-1:0]  source;
    logic [TL_AW-1:0]    address;
    logic [TL_DBW-1:0]   mask;
    logic [TL_DW-1:0]    data;

    modport master (output valid, opcode, size, source, address, mask, data, input ready);
    modport slave  (input valid, opcode, size, source, address, mask, data, output ready);

endinterface

// File: rtl/tl_rsp_fifo.sv
// Two-entry in-order FIFO of D-channel response descriptors with occupancy count.
module tl_rsp_fifo
    import tilelink_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic       push,
    input  tl_d_rsp_t  wdata,
    input  logic       pop,
    output tl_d_rsp_t  rdata,
    output logic [1:0] count
);

    tl_d_rsp_t mem [2];
    logic      wr_ptr;
    logic      rd_ptr;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= ~wr_ptr;
            if (pop)  rd_ptr <= ~rd_ptr;
            count <= count + {1'b0, push} - {1'b0, pop};
        end
    end

    // Push and pop on a full FIFO write the slot being popped this same edge.
    always_ff @(posedge clock) begin
        if (push) mem[wr_ptr] <= wdata;
    end

    assign rdata = mem[rd_ptr];

endmodule

// File: rtl/tl_ul_sram_bridge.sv
// TileLink-UL slave to single-port synchronous SRAM with a 2-deep D response buffer.
// Define TL_SRAM_BRIDGE_ERRCHK_EN to reject malformed A requests with d_error.
module tl_ul_sram_bridge
    import tilelink_pkg::*;
#(
    parameter int SRAM_AW = 10
) (
    input  logic                clock,
    input  logic                reset,
    tl_a_intf.slave             a,
    output logic                d_valid,
    input  logic                d_ready,
    output tl_d_opcode_e        d_opcode,
    output logic [1:0]          d_param,
    output logic [TL_SZW-1:0]   d_size,
    output logic [TL_SRCW-1:0]  d_source,
    output logic [TL_DW-1:0]    d_data,
    output logic                d_error,
    output logic                sram_req,
    output logic                sram_we,
    output logic [SRAM_AW-1:0]  sram_addr,
    output logic [TL_DBW-1:0]   sram_wmask,
    output logic [TL_DW-1:0]    sram_wdata,
    input  logic [TL_DW-1:0]    sram_rdata
);

    localparam int OFF = TL_OFF;

    logic       a_fire;
    logic       a_err;
    logic       is_put;
    logic       inflight;
    logic [1:0] fifo_count;
    logic       fifo_empty;
    logic       push;
    logic       pop;
    logic       unused_addr;
    tl_d_rsp_t  rsp_q;
    tl_d_rsp_t  ft_rsp;
    tl_d_rsp_t  head_rsp;
    tl_d_rsp_t  d_rsp;

    // Credit depends only on registered occupancy, never on d_ready.
    assign a.ready = reset & ((fifo_count + {1'b0, inflight}) < 2'd2);
    assign a_fire  = a.valid & a.ready;
    assign is_put  = (a.opcode == PutFullData) || (a.opcode == PutPartialData);

`ifdef TL_SRAM_BRIDGE_ERRCHK_EN
    logic [OFF-1:0] addr_lo;
    assign addr_lo = a.address[OFF-1:0];

    always_comb begin
        a_err = 1'b0;
        if (!(is_put || a.opcode == Get))                              a_err = 1'b1;
        if (a.size > TL_SZW'(OFF))                                     a_err = 1'b1;
        else if ((addr_lo & OFF'((32'd1 << a.size) - 32'd1)) != '0)    a_err = 1'b1;
        if ((a.address >> (SRAM_AW + OFF)) != '0)                      a_err = 1'b1;
        if (a.opcode == PutFullData && a.mask != tl_full_mask(a.size, addr_lo))
            a_err = 1'b1;
    end
`else
    assign a_err = 1'b0;
`endif

    assign unused_addr = ^a.address;

    assign sram_req   = a_fire & ~a_err;
    assign sram_we    = sram_req & is_put;
    assign sram_addr  = a.address[SRAM_AW+OFF-1:OFF];
    assign sram_wmask = a.mask;
    assign sram_wdata = a.data;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            inflight <= 1'b0;
            rsp_q    <= '0;
        end else begin
            inflight <= a_fire;
            if (a_fire) begin
                rsp_q.opcode <= is_put ? AccessAck : AccessAckData;
                rsp_q.size   <= a.size;
                rsp_q.source <= a.source;
                rsp_q.data   <= '0;
                rsp_q.error  <= a_err;
            end
        end
    end

    always_comb begin
        ft_rsp = rsp_q;
        if (rsp_q.opcode == AccessAckData && !rsp_q.error) ft_rsp.data = sram_rdata;
    end

    assign fifo_empty = (fifo_count == 2'd0);
    assign pop        = ~fifo_empty & d_ready;
    assign push       = inflight & ~(fifo_empty & d_ready);

    tl_rsp_fifo u_fifo (
        .clock (clock),
        .reset (reset),
        .push  (push),
        .wdata (ft_rsp),
        .pop   (pop),
        .rdata (head_rsp),
        .count (fifo_count)
    );

    assign d_rsp    = fifo_empty ? ft_rsp : head_rsp;
    assign d_valid  = inflight | ~fifo_empty;
    assign d_opcode = d_rsp.opcode;
    assign d_param  = '0;
    assign d_size   = d_rsp.size;
    assign d_source = d_rsp.source;
    assign d_data   = d_rsp.data;
    assign d_error  = d_rsp.error;

endmodule

// File: doc/tl_ul_sram_bridge.md
# tl_ul_sram_bridge

TileLink-UL slave endpoint sitting directly downstream of a `tl_a_intf` slave modport. Accepts A-channel Get/PutFullData/PutPartialData requests, drives a single-port synchronous SRAM, and returns AccessAck/AccessAckData on a D channel through a 2-entry response buffer. Sustains one request per cycle when `d_ready` stays high.

## Interface
Parameters:
- `SRAM_AW`, 10: SRAM word-address width. `OFF = $clog2(TL_DBW)`.

Ports:
- `clock`, input, 1: single clock for the whole block.
- `reset`, input, 1: asynchronous, active-low reset.
- `a`, `tl_a_intf.slave`, —: A channel; the block drives `a.ready`.
- `d_valid`, output, 1: D response valid.
- `d_ready`, input, 1: D response accepted.
- `d_opcode`, output, `tl_d_opcode_e`: AccessAck=0 for puts, AccessAckData=1 for Get.
- `d_param`, output, 2: always 0.
- `d_size`, output, `TL_SZW`: echo of `a.size`.
- `d_source`, output, `TL_SRCW`: echo of `a.source`.
- `d_data`, output, `TL_DW`: read data; 0 for puts and errored Gets.
- `d_error`, output, 1: request rejected.
- `sram_req`, output, 1: SRAM access strobe.
- `sram_we`, output, 1: 1 = write.
- `sram_addr`, output, `SRAM_AW`: `a.address[SRAM_AW+OFF-1:OFF]`.
- `sram_wmask`, output, `TL_DBW`: byte enables (`a.mask`).
- `sram_wdata`, output, `TL_DW`: `a.data`.
- `sram_rdata`, input, `TL_DW`: valid the cycle after a read `sram_req`.

## Operation
- A fire = `a.valid & a.ready`.
- `a.ready = (fifo_count + inflight) < 2`.
  - Driven from registers only; no `d_ready`→`a.ready` path.
  - Held 0 while `reset` is asserted.
- On a clean A fire:
  - `sram_req`=1 in the same cycle (combinational).
  - `sram_we`=1 for PutFull/PutPartial.
  - The response descriptor (opcode, size, source, error=0) is registered as the in-flight stage; `inflight`=1 the next cycle.
- On an errored A fire:
  - `sram_req`=0.
  - The descriptor goes in flight with error=1 and zero data.
- Response stage, cycle after the fire:
  - If the FIFO is empty, the descriptor plus `sram_rdata` falls through to the D outputs.
  - If it is not consumed that cycle (or the FIFO is non-empty), it is pushed into the FIFO.
  - Read data is captured with the entry, so later SRAM activity never corrupts it.
- D outputs show the FIFO head when non-empty, otherwise the fall-through entry; strict in-order.
- A D fire pops one entry, or consumes the fall-through.
- `d_valid`, once high, holds with stable payload until `d_ready`.
- Width rule: `sram_addr` truncates to `SRAM_AW`. Upper-address checking applies only under the macro.

## Timing
- Reset values:
  - `d_valid`=0, `d_error`=0, `d_data`=0, `d_opcode`=0, `d_size`=0, `d_source`=0.
  - `sram_req`=0.
  - `fifo_count`=0, `inflight`=0.
- Latency: A fire in cycle N → `d_valid` in cycle N+1 (fall-through), for both reads and writes.
- Throughput: 1 request/cycle with `d_ready`=1.
- Full: with `d_ready`=0, exactly 2 requests are accepted, then `a.ready`=0 until a D fire. Credit returns the cycle after the D fire.
- Simultaneous push and pop on a full FIFO is legal; count is unchanged.
- Reset mid-operation discards in-flight and queued responses. No D response is produced for them after reset.

## Configuration
- `TL_SRAM_BRIDGE_ERRCHK_EN` defined — an A fire is errored (`d_error`=1, no SRAM access) if any of:
  - opcode not in {Get, PutFull, PutPartial};
  - `a.size > OFF`;
  - address not aligned to `2**a.size`;
  - address bits above `SRAM_AW+OFF` non-zero;
  - PutFull mask not equal to the full aligned mask for its size.
- Undefined: every request reaches the SRAM; `d_error` tied 0; undefined opcodes are treated as Get.

## Structure
- In `tilelink_pkg`:
  - `tl_d_opcode_e` (AccessAck=0, AccessAckData=1);
  - packed `tl_d_rsp_t` {opcode, size, source, data, error}.
- `TL_SZW`, `TL_SRCW`, `TL_AW`, `TL_DBW`, `TL_DW` are reused from the package.
- Sub-module `tl_rsp_fifo`: 2-entry `tl_d_rsp_t` FIFO with count output; the fall-through mux stays in the top.

## Test plan
- Get addr 0x10 after PutFull addr 0x10 data 0xDEADBEEF mask 0xF, `d_ready`=1 → AccessAck at N+1, then AccessAckData `d_data`=0xDEADBEEF, `d_source` echoed.
- PutPartial addr 0x20 mask 0x3 data 0x0000ABCD over 0xFFFFFFFF, then Get → 0xFFFFABCD.
- `d_ready`=0, 3 back-to-back Gets → 2 accepted, `a.ready`=0 on the 3rd. Release `d_ready` → responses arrive in order, 3rd accepted one cycle after the first D fire.
- ERRCHK on: Get size=2 addr 0x2 → `d_error`=1, `d_data`=0, `sram_req` never high. ERRCHK off: same request → `sram_req`=1, `d_error`=0.
- 8 back-to-back Gets with `d_ready`=1 → 8 consecutive `d_valid` cycles starting 1 cycle after the first A fire.
- Assert `reset` with 2 queued responses → `d_valid`=0 immediately; after release `a.ready`=1 and no stale responses.
